// File: rtl/reset_sequencer.sv
// Staggered reset sequencer: waits for clock-manager lock, stretches, then releases channels in order.
// Optional lock timeout enabled by defining RESET_SEQ_LOCK_TIMEOUT_EN.
`timescale 1ns/1ps
module reset_sequencer #(
  parameter int NUM_RST      = 4,
  parameter int STRETCH      = 16,
  parameter int STAGGER      = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               CLK_IN,
  input  logic               RESET_IN,
  input  logic               LOCKED_IN,
  input  logic               SW_RST_IN,
  output logic [NUM_RST-1:0] RST_OUT,
  output logic               READY_OUT,
  output logic               LOCK_FAIL_OUT,
  output logic [2:0]         STATE_OUT
);

  localparam int MAX_AB = (STRETCH > STAGGER) ? STRETCH : STAGGER;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] STRETCH_END = CW'(STRETCH - 1);
  localparam logic [CW-1:0] STAGGER_END = CW'(STAGGER - 1);
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STRETCH   = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 lock_p0;
  logic                 lock_p1;
  logic [NUM_RST-1:0]   rst_q;
  logic [NUM_RST-1:0]   rst_shift;
  logic                 ready_q;
  logic                 seq_active;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Shifting a zero in at bit 0 guarantees in-order release.
  assign rst_shift  = rst_q << 1;
  assign seq_active = (state == S_STRETCH) || (state == S_RELEASE) || (state == S_RUN);

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
      state   <= S_WAIT_LOCK;
      cnt     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      lock_p0 <= LOCKED_IN;
      lock_p1 <= lock_p0;
      if (seq_active && !lock_p1) begin
        state   <= S_WAIT_LOCK;
        cnt     <= '0;
        rst_q   <= '1;
        ready_q <= 1'b0;
      end else if (seq_active && SW_RST_IN) begin
        state   <= S_STRETCH;
        cnt     <= '0;
        rst_q   <= '1;
        ready_q <= 1'b0;
      end else begin
        case (state)
          S_WAIT_LOCK: begin
            if (lock_p1) begin
              state <= S_STRETCH;
              cnt   <= '0;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
            end else if (cnt == TIMEOUT_END) begin
              state <= S_FAIL;
              cnt   <= sat_inc(cnt);
`endif
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          S_STRETCH: begin
            if (cnt == STRETCH_END) begin
              rst_q   <= rst_shift;
              cnt     <= '0;
              state   <= (NUM_RST == 1) ? S_RUN : S_RELEASE;
              ready_q <= (NUM_RST == 1);
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          S_RELEASE: begin
            if (cnt == STAGGER_END) begin
              rst_q <= rst_shift;
              cnt   <= '0;
              if (rst_shift == '0) begin
                state   <= S_RUN;
                ready_q <= 1'b1;
              end
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          S_RUN: begin
            cnt <= '0;
          end
          S_FAIL: begin
            if (lock_p1) begin
              state <= S_STRETCH;
              cnt   <= '0;
            end
          end
          default: begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
  logic fail_q;

  // Sticky until the asynchronous reset.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      fail_q <= 1'b0;
    end else if (state == S_WAIT_LOCK && !lock_p1 && cnt == TIMEOUT_END) begin
      fail_q <= 1'b1;
    end
  end

  assign LOCK_FAIL_OUT = fail_q;
`else
  assign LOCK_FAIL_OUT = 1'b0;
`endif

  assign RST_OUT   = rst_q;
  assign READY_OUT = ready_q;
  assign STATE_OUT = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: two instances (4 channels / 1 channel) against a timeline model.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int N4 = 4;
  localparam int N1 = 1;
  localparam int ST = 16;
  localparam int SG = 8;
  localparam int SG1 = 1;
  localparam int LT = 1024;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       CLK_IN = 1'b0;
  logic       RESET_IN;
  logic       LOCKED_IN;
  logic       SW_RST_IN;
  logic [3:0] rst_a;
  logic       ready_a, fail_a;
  logic [2:0] state_a;
  logic [0:0] rst_b;
  logic       ready_b, fail_b;
  logic [2:0] state_b;

  reset_sequencer #(.NUM_RST(N4), .STRETCH(ST), .STAGGER(SG), .LOCK_TIMEOUT(LT)) u_seq4 (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .LOCKED_IN(LOCKED_IN), .SW_RST_IN(SW_RST_IN),
    .RST_OUT(rst_a), .READY_OUT(ready_a), .LOCK_FAIL_OUT(fail_a), .STATE_OUT(state_a));

  reset_sequencer #(.NUM_RST(N1), .STRETCH(ST), .STAGGER(SG1), .LOCK_TIMEOUT(LT)) u_seq1 (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .LOCKED_IN(LOCKED_IN), .SW_RST_IN(SW_RST_IN),
    .RST_OUT(rst_b), .READY_OUT(ready_b), .LOCK_FAIL_OUT(fail_b), .STATE_OUT(state_b));

  always #5 CLK_IN = ~CLK_IN;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Timeline model: mode 0 waiting for lock, 1 sequence running since edge e_edge, 2 timed out.
  int cyc, e_edge, w_edge, mode;
  bit fail_flag, h1, h2, lk_drv;

  function automatic logic [31:0] exp_rst(int nr, int stg, bit act, int d);
    logic [31:0] r = '0;
    for (int i = 0; i < nr; i++) r[i] = !(act && d >= ST + i * stg);
    return r;
  endfunction

  function automatic logic [31:0] exp_ready(int nr, int stg, bit act, int d);
    return 32'(act && d >= ST + (nr - 1) * stg);
  endfunction

  function automatic logic [31:0] exp_state(int nr, int stg, int md, int d);
    if (md == 2) return 32'd4;
    if (md == 0) return 32'd0;
    if (d < ST) return 32'd1;
    if (d >= ST + (nr - 1) * stg) return 32'd3;
    return 32'd2;
  endfunction

  task automatic model_reset();
    cyc = 0; e_edge = 0; w_edge = 0; mode = 0; fail_flag = 0; h1 = 0; h2 = 0;
  endtask

  task automatic model_edge(input bit lk, input bit sw);
    bit ls;
    cyc++;
    ls = h2; h2 = h1; h1 = lk;
    if (mode == 1) begin
      if (!ls) begin mode = 0; w_edge = cyc; end
      else if (sw) e_edge = cyc;
    end else if (ls) begin
      mode = 1; e_edge = cyc;
    end else if (mode == 0 && TO_EN && cyc - w_edge == LT) begin
      mode = 2; fail_flag = 1;
    end
  endtask

  task automatic check_outputs();
    bit act;
    int d;
    act = (mode == 1);
    d = cyc - e_edge;
    chk("rst4",   32'(rst_a),   exp_rst(N4, SG, act, d));
    chk("ready4", 32'(ready_a), exp_ready(N4, SG, act, d));
    chk("state4", 32'(state_a), exp_state(N4, SG, mode, d));
    chk("fail4",  32'(fail_a),  32'(fail_flag));
    chk("rst1",   32'(rst_b),   exp_rst(N1, SG1, act, d));
    chk("ready1", 32'(ready_b), exp_ready(N1, SG1, act, d));
    chk("state1", 32'(state_b), exp_state(N1, SG1, mode, d));
    chk("fail1",  32'(fail_b),  32'(fail_flag));
  endtask

  task automatic cycle(input bit lk, input bit sw);
    LOCKED_IN = lk;
    SW_RST_IN = sw;
    @(posedge CLK_IN);
    model_edge(lk, sw);
    @(negedge CLK_IN);
    check_outputs();
    SW_RST_IN = 1'b0;
  endtask

  task automatic run_to(input int target);
    bit hit = 0;
    for (int k = 0; k < 600 && !hit; k++) begin
      if (mode == 1 && cyc - e_edge == target) hit = 1;
      else cycle(lk_drv, 1'b0);
    end
    chk("reach_target", 32'(hit), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rst4"},   32'(rst_a),   32'hF);
    chk({tag, "_ready4"}, 32'(ready_a), 32'd0);
    chk({tag, "_state4"}, 32'(state_a), 32'd0);
    chk({tag, "_fail4"},  32'(fail_a),  32'd0);
    chk({tag, "_rst1"},   32'(rst_b),   32'd1);
    chk({tag, "_ready1"}, 32'(ready_b), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2 RESET_IN = 1'b1;
    #1 check_reset_values(tag);
    @(posedge CLK_IN);
    @(negedge CLK_IN);
    check_reset_values({tag, "_held"});
    RESET_IN = 1'b0;
    model_reset();
  endtask

  initial begin
    RESET_IN = 1'b1; LOCKED_IN = 1'b0; SW_RST_IN = 1'b0; lk_drv = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK_IN);
    check_reset_values("por");
    RESET_IN = 1'b0;

    // Normal bring-up, lock arrives 200 ns after reset release.
    repeat (20) cycle(1'b0, 1'b0);
    lk_drv = 1'b1;
    run_to(ST + (N4 - 1) * SG + 5);

    // Lock glitch during the stretch.
    repeat (6) cycle(1'b0, 1'b0);
    run_to(10);
    repeat (3) cycle(1'b0, 1'b0);
    run_to(ST + (N4 - 1) * SG + 10);

    // Lock loss in RUN, then relock.
    repeat (5) cycle(1'b0, 1'b0);
    run_to(ST + (N4 - 1) * SG + 10);

    // Software reset at E+30.
    cycle(1'b1, 1'b1);
    run_to(29);
    cycle(1'b1, 1'b1);
    chk("sw_state", 32'(state_a), 32'd1);
    chk("sw_rst", 32'(rst_a), 32'hF);
    run_to(ST + (N4 - 1) * SG + 5);

    // Software reset coincident with lock loss reaching the FSM.
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("sw_vs_loss_state", 32'(state_a), 32'd0);
    repeat (3) cycle(1'b0, 1'b0);
    run_to(ST + (N4 - 1) * SG + 5);

    // Randomized lock drops, relocks and software resets.
    repeat (3000) begin
      if (lk_drv && $urandom_range(0, 99) == 0) lk_drv = 1'b0;
      else if (!lk_drv && $urandom_range(0, 7) == 0) lk_drv = 1'b1;
      cycle(lk_drv, $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset in the middle of the release (1100).
    lk_drv = 1'b1;
    repeat (4) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    run_to(ST + SG + 3);
    chk("pre_reset_rst", 32'(rst_a), 32'hC);
    do_reset("mid_release");

    // Lock never arrives: timeout path (stays waiting without the timeout feature).
    lk_drv = 1'b0;
    repeat (LT + 10) cycle(1'b0, 1'b0);
    chk("timeout_flag", 32'(fail_a), 32'(TO_EN));
    chk("timeout_state", 32'(state_a), TO_EN ? 32'd4 : 32'd0);
    lk_drv = 1'b1;
    repeat (30) cycle(1'b1, 1'b0);
    chk("relock_flag", 32'(fail_a), 32'(TO_EN));
    do_reset("after_timeout");

    lk_drv = 1'b1;
    run_to(ST + 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset sequencer for the Picoblaze system controller. It waits for the clock-manager lock, holds all downstream resets for a programmable stretch, then releases NUM_RST reset channels one at a time in a fixed staggered order. It re-asserts every channel on lock loss or on a software reset request. An optional lock timeout reports a clock manager that never locks.

## Interface
- NUM_RST, 4: number of reset channels, 1..16.
- STRETCH, 16: cycles of stable lock required before channel 0 releases, ≥1.
- STAGGER, 8: cycles between successive channel releases, ≥1.
- LOCK_TIMEOUT, 1024: cycles in WAIT_LOCK before FAIL, ≥2 (used only with the timeout macro).

- CLK_IN  in  1  system clock.
- RESET_IN  in  1  reset, asynchronous, active-high; clock CLK_IN.
- LOCKED_IN  in  1  DCM lock, asynchronous to CLK_IN.
- SW_RST_IN  in  1  synchronous software reset request, one-cycle pulse or level.
- RST_OUT  out  NUM_RST  active-high reset per channel; bit 0 releases first.
- READY_OUT  out  1  all channels released.
- LOCK_FAIL_OUT  out  1  sticky lock-timeout flag.
- STATE_OUT  out  3  FSM state: 0 WAIT_LOCK, 1 STRETCH, 2 RELEASE, 3 RUN, 4 FAIL.

## Operation
- RESET_IN high forces the following, asynchronously:
  - state WAIT_LOCK;
  - RST_OUT all ones, READY_OUT 0, LOCK_FAIL_OUT 0, STATE_OUT 0;
  - counters and synchroniser flops cleared.
- LOCKED_IN passes through a 2-flop synchroniser to give lock_s. All FSM decisions use lock_s.
- WAIT_LOCK:
  - The wait counter increments each cycle.
  - lock_s=1 → STRETCH, with the counter cleared.
- STRETCH:
  - lock_s=0 → WAIT_LOCK.
  - After STRETCH cycles → RELEASE, and RST_OUT[0] clears on that edge.
- RELEASE:
  - Every STAGGER cycles, the next channel clears.
  - When RST_OUT[NUM_RST-1] clears → RUN, with READY_OUT set on the same edge.
  - With NUM_RST=1, STRETCH goes directly to RUN.
- RUN: holds until lock loss or SW_RST_IN.
- Lock loss: lock_s=0 in STRETCH, RELEASE or RUN sets all RST_OUT to 1, READY_OUT to 0, state WAIT_LOCK, all on the next edge.
- Software reset: SW_RST_IN=1 with lock_s=1 in STRETCH, RELEASE or RUN sets all RST_OUT to 1, READY_OUT to 0, state STRETCH, counter cleared. The stretch restarts in full.
- SW_RST_IN is ignored in WAIT_LOCK and FAIL.
- If lock loss and SW_RST_IN occur in the same cycle, lock loss wins and the state goes to WAIT_LOCK.
- Channels never release out of order. RST_OUT[i]=0 implies RST_OUT[j]=0 for all j<i.
- Counter width is $clog2 of the largest of STRETCH, STAGGER and LOCK_TIMEOUT, plus 1. The counter saturates and never wraps.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- LOCKED_IN edge to FSM reaction: 2–3 CLK_IN edges (synchroniser plus FSM register).
- Let E be the edge at which the state becomes STRETCH:
  - RST_OUT[i] falls at edge E+STRETCH+i·STAGGER;
  - READY_OUT rises at E+STRETCH+(NUM_RST-1)·STAGGER.
- Lock loss visible in lock_s at edge k: all RST_OUT are high at edge k+1.
- SW_RST_IN sampled high at edge k: all RST_OUT are high at edge k+1, and the new E is k+1.
- RESET_IN deassertion: the FSM leaves reset values at the first CLK_IN edge after deassertion. RST_OUT stays high at least until E+STRETCH.

## Configuration
- Macro: RESET_SEQ_LOCK_TIMEOUT_EN.
- Defined:
  - In WAIT_LOCK, when the counter reaches LOCK_TIMEOUT-1 with lock_s=0 → FAIL, and LOCK_FAIL_OUT=1 on that edge. FAIL is entered LOCK_TIMEOUT cycles after entering WAIT_LOCK.
  - FAIL keeps all RST_OUT high.
  - lock_s=1 in FAIL → STRETCH.
  - LOCK_FAIL_OUT stays 1 until RESET_IN.
  - The counter restarts at every entry to WAIT_LOCK.
- Undefined:
  - WAIT_LOCK waits indefinitely; FAIL is unreachable.
  - LOCK_FAIL_OUT is tied 0.
  - The LOCK_TIMEOUT parameter is unused.

## Test plan
- Normal bring-up (defaults), LOCKED_IN rising 200 ns after RESET_IN falls:
  - RST_OUT steps 1111→1110→1100→1000→0000 at E+16, E+24, E+32, E+40;
  - READY_OUT=1 at E+40; STATE_OUT sequence is 0,1,2,3.
- Lock glitch: LOCKED_IN low for 3 cycles at E+10 → state returns to WAIT_LOCK, and no RST_OUT bit ever clears before a fresh E+16.
- Lock loss in RUN → all RST_OUT=1 and READY_OUT=0 within 3 edges of LOCKED_IN falling. Relock then gives the full staggered release again.
- SW_RST_IN pulse at E+30 → RST_OUT=1111 next edge, STATE_OUT=1. Channel 0 releases 16 cycles later. Repeat with SW_RST_IN coincident with lock loss → STATE_OUT=0.
- With RESET_SEQ_LOCK_TIMEOUT_EN, LOCKED_IN held low:
  - LOCK_FAIL_OUT=1 and STATE_OUT=4 exactly 1024 cycles after WAIT_LOCK entry;
  - a later lock → STRETCH with LOCK_FAIL_OUT still 1;
  - RESET_IN → LOCK_FAIL_OUT=0.
- RESET_IN asserted mid-RELEASE (RST_OUT=1100) → RST_OUT=1111, READY_OUT=0, STATE_OUT=0 immediately with no clock edge. Repeat with NUM_RST=1, STAGGER=1: RST_OUT[0] and READY_OUT change on the same edge E+16.
